// File: rtl/sn74194_if.sv
// Pin bundle of the SN74194 apart from clock and clear: power, mode select,
// serial and parallel data in, and the four registered outputs.
interface sn74194_if;
  logic P16;  // VCC
  logic P8;   // GND
  logic P9;   // S0
  logic P10;  // S1
  logic P2;   // SR
  logic P7;   // SL
  logic P3;   // A
  logic P4;   // B
  logic P5;   // C
  logic P6;   // D
  logic P15;  // QA
  logic P14;  // QB
  logic P13;  // QC
  logic P12;  // QD

  modport master (
    output P16, P8, P9, P10, P2, P7, P3, P4, P5, P6,
    input  P15, P14, P13, P12
  );

  modport slave (
    input  P16, P8, P9, P10, P2, P7, P3, P4, P5, P6,
    output P15, P14, P13, P12
  );
endinterface

// File: rtl/sn74194.sv
// SN74194 4-bit bidirectional universal shift register with asynchronous
// active-low clear; all behaviour is gated by the power pins.
module sn74194 (
  input  logic      P11,   // CLK
  input  logic      P1,    // CLR_n
  sn74194_if.slave  pins
);

  logic       powered;
  logic       clr_eff_n;
  logic       armed_reg;
  logic [3:0] q_reg;       // {QA, QB, QC, QD}
  logic [1:0] mode;
  logic [3:0] par_data;

  assign powered   = pins.P16 & ~pins.P8;
  // Clear only acts while powered; power arriving with P1 low also clears.
  assign clr_eff_n = ~(powered & ~P1);

  assign mode     = {pins.P10, pins.P9};
  assign par_data = {pins.P3, pins.P4, pins.P5, pins.P6};

  // A rising edge only counts if clear was already released at the
  // preceding falling edge, so a release coinciding with the edge is ignored.
  always_ff @(negedge P11 or negedge clr_eff_n) begin
    if (!clr_eff_n) begin
      armed_reg <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
    end
  end

  always_ff @(posedge P11 or negedge clr_eff_n) begin
    if (!clr_eff_n) begin
      q_reg <= 4'b0000;
    end else if (powered && armed_reg) begin
      case (mode)
        2'b00:   q_reg <= q_reg;
        2'b01:   q_reg <= {pins.P2, q_reg[3:1]};
        2'b10:   q_reg <= {q_reg[2:0], pins.P7};
        2'b11:   q_reg <= par_data;
        default: q_reg <= 4'bxxxx;  // unknown select corrupts the whole register
      endcase
    end
  end

  assign pins.P15 = q_reg[3];
  assign pins.P14 = q_reg[2];
  assign pins.P13 = q_reg[1];
  assign pins.P12 = q_reg[0];

endmodule

// File: tb/tb_sn74194.sv
// Directed table-driven bench for sn74194 plus hand sequences for serial
// latency and mode change coinciding with the clock edge.
module tb_sn74194;

  typedef struct {
    logic [1:0] pwr;    // {VCC, GND}
    logic       clr_n;
    logic [1:0] s;      // {S1, S0}
    logic       sr;
    logic       sl;
    logic [3:0] d;      // {A, B, C, D}
    logic       clk;    // apply one clock
    logic       rel;    // drive clr_n together with the rising edge
    logic [3:0] exp;    // {QA, QB, QC, QD}
  } vec_t;

  logic P11;
  logic P1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[32];

  sn74194_if pins();

  sn74194 dut (
    .P11  (P11),
    .P1   (P1),
    .pins (pins.slave)
  );

  function automatic vec_t mk(logic [1:0] pwr, logic clr_n, logic [1:0] s,
                              logic sr, logic sl, logic [3:0] d,
                              logic clk, logic rel, logic [3:0] exp);
    vec_t v;
    v.pwr = pwr; v.clr_n = clr_n; v.s = s; v.sr = sr; v.sl = sl;
    v.d = d; v.clk = clk; v.rel = rel; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] q;
    q = {pins.P15, pins.P14, pins.P13, pins.P12};
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, q, exp);
    end else begin
      $display("ok   %s q=%b", name, q);
    end
  endtask

  task automatic set_data(input logic [1:0] s, input logic sr, input logic sl,
                          input logic [3:0] d);
    pins.P10 = s[1]; pins.P9 = s[0];
    pins.P2 = sr; pins.P7 = sl;
    pins.P3 = d[3]; pins.P4 = d[2]; pins.P5 = d[1]; pins.P6 = d[0];
  endtask

  // Clock idles high; each tick is a falling then a rising edge.
  task automatic tick_chk(input string name, input logic [3:0] exp);
    P11 = 1'b0; #5;
    P11 = 1'b1; #1;
    check(name, exp);
    #4;
  endtask

  task automatic apply(input vec_t v, input int idx);
    pins.P16 = v.pwr[1]; pins.P8 = v.pwr[0];
    #1;
    set_data(v.s, v.sr, v.sl, v.d);
    if (!v.rel) P1 = v.clr_n;
    #1;
    if (v.clk) begin
      P11 = 1'b0; #5;
      if (v.rel) P1 = v.clr_n;
      P11 = 1'b1;
    end
    #1;
    check($sformatf("vec%0d", idx), v.exp);
    #4;
  endtask

  initial begin
    //            pwr   clr s     sr sl d        clk rel exp
    vecs[0]  = mk(2'b10, 1, 2'b11, 0, 0, 4'b1011, 1, 0, 4'b1011); // load
    vecs[1]  = mk(2'b10, 1, 2'b00, 1, 1, 4'b0100, 1, 0, 4'b1011); // hold
    vecs[2]  = mk(2'b10, 1, 2'b00, 0, 1, 4'b1111, 1, 0, 4'b1011);
    vecs[3]  = mk(2'b10, 1, 2'b00, 1, 0, 4'b0000, 1, 0, 4'b1011);
    vecs[4]  = mk(2'b10, 0, 2'b00, 0, 0, 4'b0000, 0, 0, 4'b0000); // clear
    vecs[5]  = mk(2'b10, 1, 2'b00, 0, 0, 4'b0000, 0, 0, 4'b0000);
    vecs[6]  = mk(2'b10, 1, 2'b01, 1, 0, 4'b0000, 1, 0, 4'b1000); // SR 1101
    vecs[7]  = mk(2'b10, 1, 2'b01, 1, 0, 4'b0000, 1, 0, 4'b1100);
    vecs[8]  = mk(2'b10, 1, 2'b01, 0, 0, 4'b0000, 1, 0, 4'b0110);
    vecs[9]  = mk(2'b10, 1, 2'b01, 1, 0, 4'b0000, 1, 0, 4'b1011);
    vecs[10] = mk(2'b10, 1, 2'b10, 0, 0, 4'b0000, 1, 0, 4'b0110); // SL 0
    vecs[11] = mk(2'b10, 1, 2'b10, 0, 1, 4'b0000, 1, 0, 4'b1101); // SL 1
    vecs[12] = mk(2'b10, 1, 2'b11, 0, 0, 4'b1111, 1, 0, 4'b1111); // load
    vecs[13] = mk(2'b10, 0, 2'b11, 0, 0, 4'b1111, 0, 0, 4'b0000); // clear
    vecs[14] = mk(2'b10, 1, 2'b11, 0, 0, 4'b1111, 1, 1, 4'b0000); // release at edge
    vecs[15] = mk(2'b10, 1, 2'b11, 0, 0, 4'b1111, 1, 0, 4'b1111);
    vecs[16] = mk(2'b10, 1, 2'b01, 0, 0, 4'b0000, 1, 0, 4'b0111); // mid-shift
    vecs[17] = mk(2'b10, 1, 2'b01, 0, 0, 4'b0000, 1, 0, 4'b0011);
    vecs[18] = mk(2'b10, 0, 2'b01, 1, 0, 4'b0000, 0, 0, 4'b0000);
    vecs[19] = mk(2'b10, 1, 2'b01, 1, 0, 4'b0000, 1, 0, 4'b1000); // resume
    vecs[20] = mk(2'b00, 0, 2'b01, 1, 0, 4'b0000, 0, 0, 4'b1000); // unpowered
    vecs[21] = mk(2'b00, 0, 2'b11, 0, 0, 4'b1010, 1, 0, 4'b1000);
    vecs[22] = mk(2'b00, 1, 2'b11, 0, 0, 4'b1010, 1, 0, 4'b1000);
    vecs[23] = mk(2'b10, 1, 2'b11, 0, 0, 4'b1010, 1, 0, 4'b1010); // power back
    vecs[24] = mk(2'b00, 0, 2'b11, 0, 0, 4'b1010, 0, 0, 4'b1010);
    vecs[25] = mk(2'b10, 0, 2'b11, 0, 0, 4'b1010, 0, 0, 4'b0000); // power-up clear
    vecs[26] = mk(2'b10, 1, 2'b11, 0, 0, 4'b0101, 1, 0, 4'b0101);
    vecs[27] = mk(2'b10, 0, 2'b11, 0, 0, 4'b1111, 0, 0, 4'b0000);
    vecs[28] = mk(2'b10, 0, 2'b11, 0, 0, 4'b1111, 1, 0, 4'b0000); // clock in clear
    vecs[29] = mk(2'b10, 1, 2'b11, 0, 0, 4'b1111, 1, 0, 4'b1111);
    vecs[30] = mk(2'b11, 1, 2'b11, 0, 0, 4'b0000, 1, 0, 4'b1111); // GND high
    vecs[31] = mk(2'b10, 1, 2'b11, 0, 0, 4'b0000, 1, 0, 4'b0000);

    P11 = 1'b1;
    P1  = 1'b1;
    pins.P16 = 1'b1; pins.P8 = 1'b0;
    set_data(2'b00, 1'b0, 1'b0, 4'b0000);
    #5;

    // Clear pulse with no clock sets the reset state immediately.
    P1 = 1'b0; #1;
    check("reset_clear", 4'b0000);
    #4;
    P1 = 1'b1; #5;

    for (int i = 0; i < 32; i++) apply(vecs[i], i);

    // Serial in reaches QD after four shift-right clocks.
    P1 = 1'b0; #5; P1 = 1'b1; #5;
    set_data(2'b01, 1'b1, 1'b0, 4'b0000);
    tick_chk("sr_lat1", 4'b1000);
    pins.P2 = 1'b0;
    tick_chk("sr_lat2", 4'b0100);
    tick_chk("sr_lat3", 4'b0010);
    tick_chk("sr_lat4", 4'b0001);

    // Serial in reaches QA after four shift-left clocks.
    P1 = 1'b0; #5; P1 = 1'b1; #5;
    set_data(2'b10, 1'b0, 1'b1, 4'b0000);
    tick_chk("sl_lat1", 4'b0001);
    pins.P7 = 1'b0;
    tick_chk("sl_lat2", 4'b0010);
    tick_chk("sl_lat3", 4'b0100);
    tick_chk("sl_lat4", 4'b1000);

    // Select changed in the same timestep as the rising edge takes effect.
    set_data(2'b00, 1'b0, 1'b0, 4'b0110);
    P11 = 1'b0; #5;
    pins.P10 = 1'b1; pins.P9 = 1'b1;
    P11 = 1'b1; #1;
    check("mode_at_edge", 4'b0110);
    #4;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
